sw_debounce_serializer: RTL

//   Upstream feeder for the SPI master data_in pin on the Basys3 board.
//   - Synchronises and debounces DATA_W data switches plus one GO switch.
//   - On a debounced GO rising edge, captures the data byte.
//   - Shifts the byte out MSB-first at a divided bit rate, with busy/done handshake.

---
 rtl/sw_debounce_serializer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/sw_debounce_serializer.sv
// Switch front end for the SPI master data_in pin: it synchronises and debounces the switches, then shifts the captured byte out MSB-first.
// Define SW_SER_PARITY_EN to append an odd-parity bit after the payload.
module sw_debounce_serializer #(
  parameter int DATA_W       = 8,
  parameter int DB_CYCLES    = 1000000,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              sw_go,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              bit_tick,
  output logic              busy,
  output logic              done,
  output logic [7:0]        frame_cnt
);

  localparam int VW    = DATA_W + 1;
  localparam int DB_W  = $clog2(DB_CYCLES);
  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
`ifdef SW_SER_PARITY_EN
    S_PAR,
`endif
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [VW-1:0]     sync1_q, sync1_d;
  logic [VW-1:0]     sync2_q, sync2_d;
  logic [VW-1:0]     stable_q, stable_d;
  logic              stable_go_q, stable_go_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
`ifdef SW_SER_PARITY_EN
  logic              par_q, par_d;
`endif

  logic go_rise;
  logic tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      stable_go_q <= 1'b0;
      db_cnt_q    <= '0;
      shreg_q     <= '0;
      div_q       <= '0;
      bit_q       <= '0;
      frame_cnt_q <= '0;
`ifdef SW_SER_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      stable_q    <= stable_d;
      stable_go_q <= stable_go_d;
      db_cnt_q    <= db_cnt_d;
      shreg_q     <= shreg_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef SW_SER_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    sync1_d     = {sw_go, sw_data};
    sync2_d     = sync1_q;
    stable_d    = stable_q;
    stable_go_d = stable_q[DATA_W];
    db_cnt_d    = db_cnt_q;
    shreg_d     = shreg_q;
    div_d       = div_q;
    bit_d       = bit_q;
    frame_cnt_d = frame_cnt_q;
`ifdef SW_SER_PARITY_EN
    par_d       = par_q;
`endif
    ser_out     = 1'b0;
    ser_valid   = 1'b0;
    bit_tick    = 1'b0;
    done        = 1'b0;
    busy        = (state_q != S_IDLE);

    // The shared counter only advances while the synced vector disagrees with the debounced one.
    if (sync2_q == stable_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
      stable_d = sync2_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end

    go_rise = stable_q[DATA_W] & ~stable_go_q;
    tick    = (div_q == DIV_W'(CLKS_PER_BIT - 1));

    case (state_q)
      S_IDLE: begin
        if (go_rise) begin
          shreg_d = stable_q[DATA_W-1:0];
`ifdef SW_SER_PARITY_EN
          par_d   = ~^stable_q[DATA_W-1:0];
`endif
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        div_d   = '0;
        bit_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        ser_out   = shreg_q[DATA_W-1];
        ser_valid = 1'b1;
        bit_tick  = tick;
        if (tick) begin
          shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
          div_d   = '0;
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_W'(DATA_W - 1)) begin
`ifdef SW_SER_PARITY_EN
            state_d = S_PAR;
`else
            state_d = S_DONE;
`endif
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
`ifdef SW_SER_PARITY_EN
      S_PAR: begin
        ser_out   = par_q;
        ser_valid = 1'b1;
        bit_tick  = tick;
        if (tick) begin
          div_d   = '0;
          state_d = S_DONE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
`endif
      S_DONE: begin
        done        = 1'b1;
        frame_cnt_d = frame_cnt_q + 8'd1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign frame_cnt = frame_cnt_q;

endmodule
